// File: rtl/twos_to_float_seq_pkg.sv
// Shared types and derived-size helpers for the two's-complement to float converter.
package twos_to_float_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 12;
  localparam int EXP_W_DEF  = 3;
  localparam int MANT_W_DEF = 4;

  function automatic int shift_max(input int data_w, input int mant_w);
    return data_w - mant_w;
  endfunction

  function automatic int cnt_width(input int data_w, input int mant_w);
    return $clog2(data_w - mant_w + 1);
  endfunction

  function automatic int e_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/twos_to_float_seq_round.sv
// Rounds a normalised magnitude to MANT_W bits (half up) and saturates the exponent.
module float_round_sat
  import twos_to_float_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int CNT_W  = cnt_width(DATA_W, MANT_W)
) (
  input  logic [DATA_W-1:0] mag,
  input  logic [CNT_W-1:0]  cnt,
  output logic [EXP_W-1:0]  e,
  output logic [MANT_W-1:0] f
);

  localparam int E_MAX = e_max(EXP_W);

  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] f_pre;
  logic [CNT_W:0]    e_full;
  logic              unused_mag;

  // Bits below the round bit only matter to the normaliser.
  assign unused_mag = ^mag;

  always_comb begin
    sum    = {1'b0, mag[DATA_W-1 -: MANT_W]} + {{MANT_W{1'b0}}, mag[DATA_W-1-MANT_W]};
    f_pre  = sum[MANT_W-1:0];
    e_full = {1'b0, cnt};
    e      = '0;
    f      = '0;
    if (sum[MANT_W]) begin
      f_pre  = MANT_W'(1) << (MANT_W - 1);
      e_full = {1'b0, cnt} + (CNT_W + 1)'(1);
    end
    if (int'(e_full) > E_MAX) begin
      e = '1;
      f = '1;
    end else begin
      e = EXP_W'(e_full);
      f = f_pre;
    end
  end

endmodule

// File: rtl/twos_to_float_seq.sv
// Sequential two's-complement to F*2^E converter; normalises one bit per clock.
module twos_to_float_seq
  import twos_to_float_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [MANT_W-1:0] out_f,
  output logic              busy
);

  localparam int SHIFT_MAX = shift_max(DATA_W, MANT_W);
  localparam int CNT_W     = cnt_width(DATA_W, MANT_W);

  if (!(MANT_W < DATA_W) || (e_max(EXP_W) < DATA_W - MANT_W - 1)) begin : g_bad_params
    $fatal(1, "twos_to_float_seq: unsupported DATA_W/EXP_W/MANT_W combination");
  end

  state_t            state, state_nxt;
  logic              sign;
  logic [DATA_W-1:0] mag;
  logic [CNT_W-1:0]  cnt;
  logic [EXP_W-1:0]  e_rnd;
  logic [MANT_W-1:0] f_rnd;
  logic              norm_done;

  assign norm_done = mag[DATA_W-1] || (cnt == '0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign  <= 1'b0;
      mag   <= '0;
      cnt   <= '0;
      out_s <= 1'b0;
      out_e <= '0;
      out_f <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= in_d[DATA_W-1];
          // Negating the most negative value wraps to 1 followed by zeros, as wanted.
          mag  <= in_d[DATA_W-1] ? (DATA_W'(0) - in_d) : in_d;
          cnt  <= CNT_W'(SHIFT_MAX);
        end
        NORM: if (!norm_done) begin
          mag <= mag << 1;
          cnt <= cnt - CNT_W'(1);
        end
        ROUND: begin
          out_s <= sign;
          out_e <= e_rnd;
          out_f <= f_rnd;
        end
        default: ;
      endcase
    end
  end

  float_round_sat #(
    .DATA_W(DATA_W),
    .EXP_W (EXP_W),
    .MANT_W(MANT_W),
    .CNT_W (CNT_W)
  ) u_round (
    .mag(mag),
    .cnt(cnt),
    .e  (e_rnd),
    .f  (f_rnd)
  );

endmodule

// File: tb/tb_twos_to_float_seq.sv
// Directed-vector bench for twos_to_float_seq with hand-computed results and latencies.
module tb_twos_to_float_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  twos_to_float_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_e    (out_e),
    .out_f    (out_f),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid is seen (0 if it never rises).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) n = 0;
  endtask

  task automatic convert(input string tag, input logic [11:0] din, input logic s,
                         input logic [2:0] e, input logic [3:0] f, input int lat,
                         input bit release_out);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_d     = ~din;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".in_ready"}, in_ready, 0);
    wait_valid(n);
    check({tag, ".latency"}, n, lat);
    check({tag, ".s"}, out_s, s);
    check({tag, ".e"}, out_e, e);
    check({tag, ".f"}, out_f, f);
    if (release_out) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".drop_valid"}, out_valid, 0);
      check({tag, ".idle"}, in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.outs", {out_s, out_e, out_f}, 0);
    @(negedge clk);
    rst = 1'b0;

    convert("v3ff", 12'h3FF, 1'b0, 3'd7, 4'd8,  4,  1'b1);
    convert("vff1", 12'hFF1, 1'b1, 3'd0, 4'd15, 10, 1'b1);
    convert("v800", 12'h800, 1'b1, 3'd7, 4'd15, 2,  1'b1);
    convert("v7ff", 12'h7FF, 1'b0, 3'd7, 4'd15, 3,  1'b1);
    convert("v02c", 12'h02C, 1'b0, 3'd2, 4'd11, 8,  1'b1);
    convert("v000", 12'h000, 1'b0, 3'd0, 4'd0,  10, 1'b1);
    convert("v07d", 12'h07D, 1'b0, 3'd4, 4'd8,  7,  1'b1);

    // Abort mid-normalisation; the leftover outputs from v07d are nonzero.
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 12'h001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.in_ready", in_ready, 1);
    check("abort.busy", busy, 0);
    check("abort.outs", {out_s, out_e, out_f}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort.no_result", seen, 0);

    // Backpressure: a pending sample must not be taken while the result is held.
    convert("bp", 12'h07D, 1'b0, 3'd4, 4'd8, 7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_d     = 12'h02C;
      @(posedge clk); #1;
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_data", {out_s, out_e, out_f}, {1'b0, 3'd4, 4'd8});
      check("bp.in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release_valid", out_valid, 0);
    check("bp.release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_d     = 12'h000;
    check("bp.second_accept", busy, 1);
    wait_valid(n);
    check("bp.second_latency", n, 8);
    check("bp.second_data", {out_s, out_e, out_f}, {1'b0, 3'd2, 4'd11});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.second_done", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
